mac_array_ctrl: RTL and testbench

//  Sequencer for one mac_array instance: accepts a job (K input vectors), clears/loads the

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_array_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mac_array_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array and its sequencer.
// Contents:
//   ctrl_state_e                - sequencer state encoding
//   DEF_ARRAY_SIZE              - default number of MAC lanes
//   DEF_INPUT_DATA_WIDTH        - default bits per lane operand
//   DEF_ACCUMULATOR_DATA_WIDTH  - default bits per lane accumulator
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    RESULT
  } ctrl_state_e;

  localparam int unsigned DEF_ARRAY_SIZE             = 2;
  localparam int unsigned DEF_INPUT_DATA_WIDTH       = 4;
  localparam int unsigned DEF_ACCUMULATOR_DATA_WIDTH = 16;

endpackage

// File: rtl/mac_array_ctrl.sv
// Sequencer for one mac_array instance. Accepts a job of K operand vectors,
// clears the array, streams K vectors into it, waits out the array latency,
// then captures and holds the accumulator vector until it is consumed.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   cmd_valid/cmd_ready   job request handshake, cmd_len = K sampled on accept
//   in_valid/in_ready     operand vector handshake, in_data = operand vector
//   mac_load_en           clears the array accumulators (one cycle per job)
//   mac_compute           one accumulate step per accepted operand vector
//   mac_in                operand vector to the array (passthrough in COMPUTE)
//   mac_acc               accumulator vector from the array
//   res_valid/res_ready   result handshake, res_data held until consumed
//   busy                  high in every state except IDLE
//
// Build option MAC_ARRAY_CTRL_PERF_CNT_EN adds saturating counters:
//   perf_jobs   result handshakes
//   perf_stall  COMPUTE cycles with in_valid low
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE             = DEF_ARRAY_SIZE,
  parameter int unsigned INPUT_DATA_WIDTH       = DEF_INPUT_DATA_WIDTH,
  parameter int unsigned ACCUMULATOR_DATA_WIDTH = DEF_ACCUMULATOR_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH              = 8,
  parameter int unsigned PIPE_LATENCY           = 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                cmd_valid,
  output logic                                                cmd_ready,
  input  logic [LEN_WIDTH-1:0]                                cmd_len,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [ARRAY_SIZE-1:0][INPUT_DATA_WIDTH-1:0]         in_data,
  output logic                                                mac_load_en,
  output logic                                                mac_compute,
  output logic [ARRAY_SIZE-1:0][INPUT_DATA_WIDTH-1:0]         mac_in,
  input  logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]   mac_acc,
  output logic                                                res_valid,
  input  logic                                                res_ready,
  output logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]   res_data,
  output logic                                                busy
`ifdef MAC_ARRAY_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                                         perf_jobs,
  output logic [31:0]                                         perf_stall
`endif
);

  // One down-counter serves both the beat count and the drain wait, so it
  // must be wide enough for either.
  localparam int unsigned PL_W  = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam int unsigned CNT_W = (LEN_WIDTH > PL_W) ? LEN_WIDTH : PL_W;

  // DRAIN exits when the counter is zero, giving max(PIPE_LATENCY,1) cycles.
  localparam logic [CNT_W-1:0] DRAIN_INIT =
    (PIPE_LATENCY > 0) ? CNT_W'(PIPE_LATENCY - 1) : '0;

  ctrl_state_e      state;
  ctrl_state_e      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             capture;
  logic             result_done;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    mac_load_en = 1'b0;
    mac_compute = 1'b0;
    capture     = 1'b0;
    result_done = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cnt_nxt   = CNT_W'(cmd_len);
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        mac_load_en = 1'b1;
        if (cnt == '0) begin
          cnt_nxt   = DRAIN_INIT;
          state_nxt = DRAIN;
        end else begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        in_ready    = 1'b1;
        mac_compute = in_valid;
        if (in_valid) begin
          if (cnt == CNT_W'(1)) begin
            cnt_nxt   = DRAIN_INIT;
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESULT: begin
        if (res_ready) begin
          result_done = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign mac_in = (state == COMPUTE) ? in_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        res_data  <= mac_acc;
        res_valid <= 1'b1;
      end else if (result_done) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef MAC_ARRAY_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs  <= '0;
      perf_stall <= '0;
    end else begin
      if (result_done && (perf_jobs != '1)) begin
        perf_jobs <= perf_jobs + 32'd1;
      end
      if ((state == COMPUTE) && !in_valid && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl wrapped around a behavioural MAC array
// (lane 0 weight 3, lane 1 weight 5, one-cycle accumulate latency).
// Perf counter checks are active when MAC_ARRAY_CTRL_PERF_CNT_EN is defined.
module tb_mac_array_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_len;
  logic              in_valid;
  logic              in_ready;
  logic [1:0][3:0]   in_data;
  logic              mac_load_en;
  logic              mac_compute;
  logic [1:0][3:0]   mac_in;
  logic [1:0][15:0]  mac_acc = '0;
  logic              res_valid;
  logic              res_ready;
  logic [1:0][15:0]  res_data;
  logic              busy;
`ifdef MAC_ARRAY_CTRL_PERF_CNT_EN
  logic [31:0]       perf_jobs;
  logic [31:0]       perf_stall;
`endif

  mac_array_ctrl #(
    .ARRAY_SIZE(2),
    .INPUT_DATA_WIDTH(4),
    .ACCUMULATOR_DATA_WIDTH(16),
    .LEN_WIDTH(8),
    .PIPE_LATENCY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len(cmd_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .mac_load_en(mac_load_en),
    .mac_compute(mac_compute),
    .mac_in(mac_in),
    .mac_acc(mac_acc),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .busy(busy)
`ifdef MAC_ARRAY_CTRL_PERF_CNT_EN
    ,
    .perf_jobs(perf_jobs),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural mac_array
  always @(posedge clk) begin
    if (mac_load_en) begin
      mac_acc <= '0;
    end else if (mac_compute) begin
      mac_acc[0] <= mac_acc[0] + 16'(mac_in[0]) * 16'd3;
      mac_acc[1] <= mac_acc[1] + 16'(mac_in[1]) * 16'd5;
    end
  end

  // Event monitors, sampled mid-cycle
  int cyc = 0;
  int n_load = 0, n_comp = 0, n_inrdy = 0, n_both = 0, n_cmis = 0, n_hs = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (mac_load_en) n_load++;
    if (mac_compute) n_comp++;
    if (in_ready) n_inrdy++;
    if (mac_load_en && mac_compute) n_both++;
    if (mac_compute !== (in_valid && in_ready)) n_cmis++;
    if (res_valid && res_ready) n_hs++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  logic [3:0] v0 [256];
  logic [3:0] v1 [256];

  // Called at posedge+1; returns at posedge+1 after the accept edge (DUT in LOAD).
  task automatic start_cmd(input logic [7:0] len, output int t);
    bit got = 0;
    t = -1;
    cmd_valid = 1'b1;
    cmd_len   = len;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        t   = cyc;
        got = 1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!got) check("cmd_accept_timeout", 0, 1);
  endtask

  // Offers vectors from v0/v1; pat[p] gives in_valid for the p-th cycle that
  // in_ready is high (patlen 0 means always valid).
  task automatic feed(input int n, input logic [15:0] pat, input int patlen);
    int idx = 0;
    int p = 0;
    int guard = 0;
    while (idx < n && guard < 1000) begin
      in_valid = (p < patlen) ? pat[p] : 1'b1;
      in_data  = {v1[idx], v0[idx]};
      @(negedge clk);
      if (in_ready) begin
        p++;
        if (in_valid) idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < n) check("feed_timeout", 0, 1);
  endtask

  // Returns at the negedge of the first cycle res_valid is high.
  task automatic wait_result(output int t);
    bit got = 0;
    t = -1;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (res_valid) begin
        t   = cyc;
        got = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) check("result_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ta, tr, l0, c0, r0, hs0, h;
    bit ok;
    logic [1:0][15:0] snap;

    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0;
    in_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {cmd_ready, busy, res_valid, in_ready, mac_load_en, mac_compute}, 6'b100000);
    check("reset_data", {res_data, mac_in}, '0);
    @(posedge clk); #1;

    // Test 1: K=3 back-to-back
    res_ready = 1'b1;
    v0[0] = 1; v0[1] = 2; v0[2] = 3;
    v1[0] = 4; v1[1] = 5; v1[2] = 6;
    l0 = n_load; c0 = n_comp;
    start_cmd(8'd3, ta);
    feed(3, '0, 0);
    wait_result(tr);
    check("t1_latency", tr - ta, 6);
    check("t1_res_data", res_data, {16'd75, 16'd18});
    check("t1_cmd_ready_in_result", cmd_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_after_hs", {res_valid, cmd_ready, busy}, 3'b010);
    check("t1_loads", n_load - l0, 1);
    check("t1_computes", n_comp - c0, 3);
    @(posedge clk); #1;

    // Test 2: K=0
    l0 = n_load; c0 = n_comp; r0 = n_inrdy;
    start_cmd(8'd0, ta);
    wait_result(tr);
    check("t2_latency", tr - ta, 3);
    check("t2_res_data", res_data, 0);
    @(posedge clk); #1;
    check("t2_loads", n_load - l0, 1);
    check("t2_computes", n_comp - c0, 0);
    check("t2_in_ready", n_inrdy - r0, 0);

    // Test 3: K=4 with in_valid 1,0,0,1,1,0,1
    v0[0] = 2; v0[1] = 4; v0[2] = 6; v0[3] = 8;
    v1[0] = 1; v1[1] = 3; v1[2] = 5; v1[3] = 7;
    c0 = n_comp; r0 = n_inrdy;
    start_cmd(8'd4, ta);
    feed(4, 16'b1011001, 7);
    wait_result(tr);
    check("t3_res_data", res_data, {16'd80, 16'd60});
    check("t3_computes", n_comp - c0, 4);
    check("t3_compute_cycles", n_inrdy - r0, 7);
    check("t3_latency", tr - ta, 10);
`ifdef MAC_ARRAY_CTRL_PERF_CNT_EN
    check("t3_perf_stall", perf_stall, 3);
`endif
    @(posedge clk); #1;

    // Test 4: result back-pressure, queued command
    res_ready = 1'b0;
    v0[0] = 15; v1[0] = 15;
    start_cmd(8'd1, ta);
    feed(1, '0, 0);
    wait_result(tr);
    snap = res_data;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        cmd_valid = 1'b1;
        cmd_len   = 8'd2;
      end
      @(negedge clk);
      if (!res_valid || res_data !== snap || cmd_ready) ok = 0;
    end
    check("t4_hold_stable", ok, 1);
    check("t4_res_data", res_data, {16'd75, 16'd45});
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    h = cyc;
    check("t4_handshake", res_valid && res_ready, 1);
    check("t4_no_early_cmd", cmd_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_accept_next", {cmd_ready && cmd_valid, 32'(cyc - h)}, {1'b1, 32'd1});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
`ifdef MAC_ARRAY_CTRL_PERF_CNT_EN
    check("t4_perf_jobs_1", perf_jobs, 4);
`endif
    v0[0] = 1; v0[1] = 1; v1[0] = 2; v1[1] = 2;
    feed(2, '0, 0);
    wait_result(tr);
    check("t4_res_data_2", res_data, {16'd20, 16'd6});
    @(posedge clk); #1;
    @(negedge clk);
`ifdef MAC_ARRAY_CTRL_PERF_CNT_EN
    check("t4_perf_jobs_2", perf_jobs, 5);
`endif
    @(posedge clk); #1;

    // Test 5: reset mid-COMPUTE
    v0[0] = 9; v0[1] = 9; v1[0] = 9; v1[1] = 9;
    start_cmd(8'd5, ta);
    feed(2, '0, 0);
    hs0 = n_hs;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_after_rst", {cmd_ready, busy, res_valid, in_ready, mac_load_en, mac_compute}, 6'b100000);
`ifdef MAC_ARRAY_CTRL_PERF_CNT_EN
    check("t5_perf_cleared", {perf_jobs, perf_stall}, 0);
`endif
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("t5_no_result", {n_hs - hs0, 31'd0, res_valid}, 0);
    v0[0] = 3; v0[1] = 4; v1[0] = 1; v1[1] = 2;
    start_cmd(8'd2, ta);
    feed(2, '0, 0);
    wait_result(tr);
    check("t5_res_data", res_data, {16'd15, 16'd21});
    @(posedge clk); #1;

    // Test 6: K=255
    for (int i = 0; i < 256; i++) begin
      v0[i] = 4'(i % 16);
      v1[i] = 4'd15;
    end
    c0 = n_comp;
    start_cmd(8'd255, ta);
    feed(255, '0, 0);
    wait_result(tr);
    check("t6_latency", tr - ta, 258);
    check("t6_res_data", res_data, {16'd19125, 16'd5715});
    check("t6_computes", n_comp - c0, 255);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_idle", {cmd_ready, busy, res_valid}, 3'b100);

    check("load_compute_overlap", n_both, 0);
    check("compute_vs_handshake", n_cmis, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
